alu_ctrl_stage: RTL and testbench

- Instruction-side producer of the ALU control interface: decodes the ID-stage MIPS instruction into the 5-bit ALU operation code, sign flag and operand-select controls.
- Registers the decoded controls into the ID/EX pipeline boundary, with stall (hold), flush (bubble) and valid tracking.
- Keeps a saturating count of illegal (undecodable) instructions that reach EX.
- Sits between the decoder and the EX-stage ALU; EX consumes its outputs directly.

---
 rtl/alu_ctrl_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_stage
// Description : Decodes the ID-stage MIPS instruction into ALU control fields
//               and registers them across the ID/EX boundary, with stall, flush,
//               valid tracking and a saturating illegal-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       ex_alu_ctrl,
    output logic             ex_sign,
    output logic             ex_shamt_sel,
    output logic [4:0]       ex_shamt,
    output logic             ex_imm_sel,
    output logic             ex_imm_zext,
    output logic             ex_illegal,
    output logic             ex_valid,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [4:0] c_ALU_ADD = 5'd0;
    localparam logic [4:0] c_ALU_SUB = 5'd1;
    localparam logic [4:0] c_ALU_AND = 5'd2;
    localparam logic [4:0] c_ALU_OR  = 5'd3;
    localparam logic [4:0] c_ALU_XOR = 5'd4;
    localparam logic [4:0] c_ALU_NOR = 5'd5;
    localparam logic [4:0] c_ALU_SLL = 5'd6;
    localparam logic [4:0] c_ALU_SRL = 5'd7;
    localparam logic [4:0] c_ALU_SRA = 5'd8;
    localparam logic [4:0] c_ALU_SLT = 5'd9;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_instr_shamt;

    logic [4:0] w_alu_ctrl;
    logic       w_sign;
    logic       w_shamt_sel;
    logic [4:0] w_shamt;
    logic       w_imm_sel;
    logic       w_imm_zext;
    logic       w_illegal;

    logic       w_load;
    logic       w_count;

    logic [4:0]       r_alu_ctrl;
    logic             r_sign;
    logic             r_shamt_sel;
    logic [4:0]       r_shamt;
    logic             r_imm_sel;
    logic             r_imm_zext;
    logic             r_illegal;
    logic             r_valid;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_op          = id_instr[31:26];
    assign w_funct       = id_instr[5:0];
    assign w_instr_shamt = id_instr[10:6];

    always_comb begin
        w_alu_ctrl  = c_ALU_ADD;
        w_sign      = 1'b0;
        w_shamt_sel = 1'b0;
        w_shamt     = 5'd0;
        w_imm_sel   = 1'b0;
        w_imm_zext  = 1'b0;
        w_illegal   = 1'b0;

        if (w_op == 6'h00) begin
            case (w_funct)
                6'h20: begin w_alu_ctrl = c_ALU_ADD; w_sign = 1'b1; end
                6'h21: w_alu_ctrl = c_ALU_ADD;
                6'h22: begin w_alu_ctrl = c_ALU_SUB; w_sign = 1'b1; end
                6'h23: w_alu_ctrl = c_ALU_SUB;
                6'h24: w_alu_ctrl = c_ALU_AND;
                6'h25: w_alu_ctrl = c_ALU_OR;
                6'h26: w_alu_ctrl = c_ALU_XOR;
                6'h27: w_alu_ctrl = c_ALU_NOR;
                6'h2A: begin w_alu_ctrl = c_ALU_SLT; w_sign = 1'b1; end
                6'h2B: w_alu_ctrl = c_ALU_SLT;
                // Constant shifts take the amount from the instruction field
                6'h00: begin
                    w_alu_ctrl  = c_ALU_SLL;
                    w_shamt_sel = 1'b1;
                    w_shamt     = w_instr_shamt;
                end
                6'h02: begin
                    w_alu_ctrl  = c_ALU_SRL;
                    w_shamt_sel = 1'b1;
                    w_shamt     = w_instr_shamt;
                end
                6'h03: begin
                    w_alu_ctrl  = c_ALU_SRA;
                    w_shamt_sel = 1'b1;
                    w_shamt     = w_instr_shamt;
                end
                6'h04: w_alu_ctrl = c_ALU_SLL;
                6'h06: w_alu_ctrl = c_ALU_SRL;
                6'h07: w_alu_ctrl = c_ALU_SRA;
                6'h08: w_alu_ctrl = c_ALU_ADD;
                default: w_illegal = 1'b1;
            endcase
        end else begin
            w_imm_sel = 1'b1;
            case (w_op)
                6'h08: begin w_alu_ctrl = c_ALU_ADD; w_sign = 1'b1; end
                6'h09: w_alu_ctrl = c_ALU_ADD;
                6'h0C: begin w_alu_ctrl = c_ALU_AND; w_imm_zext = 1'b1; end
                6'h0D: begin w_alu_ctrl = c_ALU_OR;  w_imm_zext = 1'b1; end
                6'h0E: begin w_alu_ctrl = c_ALU_XOR; w_imm_zext = 1'b1; end
                6'h0A: begin w_alu_ctrl = c_ALU_SLT; w_sign = 1'b1; end
                6'h0B: w_alu_ctrl = c_ALU_SLT;
                6'h23,
                6'h2B: begin w_alu_ctrl = c_ALU_ADD; w_sign = 1'b1; end
                // lui: immediate shifted left by a fixed 16
                6'h0F: begin
                    w_alu_ctrl  = c_ALU_SLL;
                    w_shamt_sel = 1'b1;
                    w_shamt     = 5'd16;
                end
                6'h04,
                6'h05: begin w_alu_ctrl = c_ALU_SUB; w_imm_sel = 1'b0; end
                6'h02,
                6'h03: w_alu_ctrl = c_ALU_ADD;
                default: begin
                    w_imm_sel = 1'b0;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_load  = !flush && !stall;
    assign w_count = w_load && id_valid && w_illegal && (r_illegal_cnt != c_CNT_MAX);

    // Flush and invalid loads both produce the all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_ctrl  <= c_ALU_ADD;
            r_sign      <= 1'b0;
            r_shamt_sel <= 1'b0;
            r_shamt     <= 5'd0;
            r_imm_sel   <= 1'b0;
            r_imm_zext  <= 1'b0;
            r_illegal   <= 1'b0;
            r_valid     <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            r_alu_ctrl  <= c_ALU_ADD;
            r_sign      <= 1'b0;
            r_shamt_sel <= 1'b0;
            r_shamt     <= 5'd0;
            r_imm_sel   <= 1'b0;
            r_imm_zext  <= 1'b0;
            r_illegal   <= 1'b0;
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_alu_ctrl  <= w_alu_ctrl;
            r_sign      <= w_sign;
            r_shamt_sel <= w_shamt_sel;
            r_shamt     <= w_shamt;
            r_imm_sel   <= w_imm_sel;
            r_imm_zext  <= w_imm_zext;
            r_illegal   <= w_illegal;
            r_valid     <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal_cnt <= '0;
        end else if (w_count) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign ex_alu_ctrl  = r_alu_ctrl;
    assign ex_sign      = r_sign;
    assign ex_shamt_sel = r_shamt_sel;
    assign ex_shamt     = r_shamt;
    assign ex_imm_sel   = r_imm_sel;
    assign ex_imm_zext  = r_imm_zext;
    assign ex_illegal   = r_illegal;
    assign ex_valid     = r_valid;
    assign illegal_cnt  = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_stage
// Description : Directed self-checking bench for alu_ctrl_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

    logic        clk;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        stall;
    logic        flush;

    logic [4:0]  ex_alu_ctrl;
    logic        ex_sign;
    logic        ex_shamt_sel;
    logic [4:0]  ex_shamt;
    logic        ex_imm_sel;
    logic        ex_imm_zext;
    logic        ex_illegal;
    logic        ex_valid;
    logic [7:0]  illegal_cnt;

    logic [4:0]  s_alu_ctrl;
    logic        s_sign;
    logic        s_shamt_sel;
    logic [4:0]  s_shamt;
    logic        s_imm_sel;
    logic        s_imm_zext;
    logic        s_illegal;
    logic        s_valid;
    logic [1:0]  s_illegal_cnt;

    int n_checks;
    int n_pass;

    localparam logic [31:0] c_ADDU  = 32'h012A4021;
    localparam logic [31:0] c_SUB   = 32'h012A4022;
    localparam logic [31:0] c_AND   = 32'h012A4024;
    localparam logic [31:0] c_SLTI  = 32'h29280005;
    localparam logic [31:0] c_SRA5  = 32'h00094143;
    localparam logic [31:0] c_LUI   = 32'h3C081234;
    localparam logic [31:0] c_ORI   = 32'h352800FF;
    localparam logic [31:0] c_ILLOP = 32'hFC000000;

    alu_ctrl_stage #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_sign(ex_sign), .ex_shamt_sel(ex_shamt_sel),
        .ex_shamt(ex_shamt), .ex_imm_sel(ex_imm_sel), .ex_imm_zext(ex_imm_zext),
        .ex_illegal(ex_illegal), .ex_valid(ex_valid), .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush),
        .ex_alu_ctrl(s_alu_ctrl), .ex_sign(s_sign), .ex_shamt_sel(s_shamt_sel),
        .ex_shamt(s_shamt), .ex_imm_sel(s_imm_sel), .ex_imm_zext(s_imm_zext),
        .ex_illegal(s_illegal), .ex_valid(s_valid), .illegal_cnt(s_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {ctrl, sign, shamt_sel, shamt, imm_sel, imm_zext, illegal, valid}
    function automatic logic [15:0] pack(input logic [4:0] ctrl, input logic sign,
                                         input logic shsel, input logic [4:0] sh,
                                         input logic imm, input logic zext,
                                         input logic ill, input logic vld);
        return {ctrl, sign, shsel, sh, imm, zext, ill, vld};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_ex(input string tag, input logic [15:0] exp);
        check(tag, {16'd0, pack(ex_alu_ctrl, ex_sign, ex_shamt_sel, ex_shamt,
                                ex_imm_sel, ex_imm_zext, ex_illegal, ex_valid)},
              {16'd0, exp});
    endtask

    task automatic step(input logic [31:0] instr, input logic vld,
                        input logic stl, input logic fl);
        @(negedge clk);
        id_instr = instr;
        id_valid = vld;
        stall    = stl;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        id_instr = 32'd0;
        id_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ex("reset_fields", pack(5'd0, 0, 0, 5'd0, 0, 0, 0, 0));
        check("reset_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        step(c_ADDU, 1, 0, 0);
        check_ex("addu", pack(5'd0, 0, 0, 5'd0, 0, 0, 0, 1));

        // Asynchronous reset between edges clears outputs without a clock
        step(c_SLTI, 1, 0, 0);
        check_ex("slti", pack(5'd9, 1, 0, 5'd0, 1, 0, 0, 1));
        #2 reset = 1'b1;
        #1;
        check_ex("async_reset", pack(5'd0, 0, 0, 5'd0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        step(c_SRA5, 1, 0, 0);
        check_ex("sra5", pack(5'd8, 0, 1, 5'd5, 0, 0, 0, 1));
        step(c_LUI, 1, 0, 0);
        check_ex("lui", pack(5'd6, 0, 1, 5'd16, 1, 0, 0, 1));
        step(c_ORI, 1, 0, 0);
        check_ex("ori", pack(5'd3, 0, 0, 5'd0, 1, 1, 0, 1));

        step(c_SUB, 1, 0, 0);
        check_ex("sub", pack(5'd1, 1, 0, 5'd0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            step(c_AND, 1, 1, 0);
            check_ex("stall_hold", pack(5'd1, 1, 0, 5'd0, 0, 0, 0, 1));
        end
        step(c_AND, 1, 0, 0);
        check_ex("and_after_stall", pack(5'd2, 0, 0, 5'd0, 0, 0, 0, 1));

        step(c_ILLOP, 1, 1, 1);
        check_ex("flush_over_stall", pack(5'd0, 0, 0, 5'd0, 0, 0, 0, 0));
        check("flush_cnt", {24'd0, illegal_cnt}, 32'd0);

        step(c_ILLOP, 1, 0, 0);
        check_ex("illegal_load", pack(5'd0, 0, 0, 5'd0, 0, 0, 1, 1));
        check("illegal_cnt1", {24'd0, illegal_cnt}, 32'd1);
        step(c_ILLOP, 0, 0, 0);
        check_ex("illegal_invalid", pack(5'd0, 0, 0, 5'd0, 0, 0, 0, 0));
        check("invalid_cnt", {24'd0, illegal_cnt}, 32'd1);
        step(c_ILLOP, 1, 1, 0);
        check("stall_cnt", {24'd0, illegal_cnt}, 32'd1);

        // Saturation on the narrow counter; reset both instances first
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("sat_reset", {30'd0, s_illegal_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(c_ILLOP, 1, 0, 0);
        check("sat_1", {30'd0, s_illegal_cnt}, 32'd1);
        step(c_ILLOP, 1, 0, 0);
        check("sat_2", {30'd0, s_illegal_cnt}, 32'd2);
        step(c_ILLOP, 1, 0, 0);
        check("sat_3", {30'd0, s_illegal_cnt}, 32'd3);
        step(c_ILLOP, 1, 0, 0);
        check("sat_4", {30'd0, s_illegal_cnt}, 32'd3);
        step(c_ILLOP, 1, 0, 0);
        check("sat_5", {30'd0, s_illegal_cnt}, 32'd3);
        check("wide_cnt_5", {24'd0, illegal_cnt}, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
